// File: rtl/ps2_key_rx_if.sv
// -----------------------------------------------------------------------------
// ps2_key_rx_if
// Key-event stream from the PS/2 receiver to the game core.
//   evt_valid  : head of the event FIFO holds an event
//   evt_ready  : consumer accepts the head event this cycle
//   evt_code   : scan code with E0/F0 prefixes stripped
//   evt_ext    : event was preceded by E0
//   evt_break  : event was preceded by F0 (key release)
// master = event producer (receiver), slave = event consumer (game core).
// -----------------------------------------------------------------------------
interface ps2_key_rx_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ext,
        output evt_break,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ext,
        input  evt_break,
        output evt_ready
    );
endinterface

// File: rtl/ps2_key_rx.sv
// -----------------------------------------------------------------------------
// ps2_key_rx
// PS/2 keyboard receiver. Deglitches the raw PS/2 clock/data pins, deserialises
// 11-bit device-to-host frames, folds E0/F0 prefixes into single key events and
// buffers them in a first-word-fall-through FIFO with a valid/ready handshake.
//
// Ports:
//   iCLK       in   system clock (25 MHz video clock)
//   iRST_N     in   asynchronous active-low reset
//   iPS2_CLK   in   raw PS/2 clock pin (asynchronous)
//   iPS2_DAT   in   raw PS/2 data pin (asynchronous)
//   evt        if   event stream (master side), see ps2_key_rx_if
//   oFRAME_ERR out  one-cycle pulse: bad start/stop/parity bit or timeout
//   oOVERFLOW  out  one-cycle pulse: event dropped because the FIFO was full
// -----------------------------------------------------------------------------
module ps2_key_rx #(
    parameter int FILTER_LEN     = 4,      // 1..15 stable cycles to accept a change
    parameter int TIMEOUT_CYCLES = 50000,  // max idle cycles between bits in a frame
    parameter int FIFO_DEPTH     = 4       // power of 2, >= 2
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iPS2_CLK,
    input  logic            iPS2_DAT,
    ps2_key_rx_if.master    evt,
    output logic            oFRAME_ERR,
    output logic            oOVERFLOW
);

    localparam int FW = 4;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    // ------------------------------------------------------------------
    // Input conditioning: line 0 = PS/2 clock, line 1 = PS/2 data.
    // ------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] line_filt;

    assign pin_raw = {iPS2_DAT, iPS2_CLK};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic          sync1_reg;
            logic          sync2_reg;
            logic          filt_reg;
            logic [FW-1:0] fcnt_reg;

            // Bus idles high, so every stage resets to 1 to avoid a
            // spurious falling edge right after reset.
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    fcnt_reg  <= '0;
                end else begin
                    sync1_reg <= pin_raw[gi];
                    sync2_reg <= sync1_reg;
                    // Count consecutive cycles of disagreement; any agreement
                    // restarts the count so short glitches are rejected.
                    if (sync2_reg == filt_reg) begin
                        fcnt_reg <= '0;
                    end else if (fcnt_reg == FW'(FILTER_LEN - 1)) begin
                        filt_reg <= sync2_reg;
                        fcnt_reg <= '0;
                    end else begin
                        fcnt_reg <= fcnt_reg + FW'(1);
                    end
                end
            end

            assign line_filt[gi] = filt_reg;
        end
    endgenerate

    logic clk_prev_reg;
    logic strobe_reg;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            clk_prev_reg <= 1'b1;
            strobe_reg   <= 1'b0;
        end else begin
            clk_prev_reg <= line_filt[0];
            strobe_reg   <= clk_prev_reg & ~line_filt[0];
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and prefix decoder
    // ------------------------------------------------------------------
    logic [1:0]    state_reg;
    logic [3:0]    bitcnt_reg;
    logic [10:0]   shift_reg;
    logic [TW-1:0] tcnt_reg;
    logic          ext_pend_reg;
    logic          brk_pend_reg;
    logic          frame_err_reg;

    logic [7:0]    rx_byte;
    logic          frame_good;
    logic          is_prefix;
    logic          push;
    logic [9:0]    push_data;

    assign rx_byte    = shift_reg[8:1];
    assign frame_good = ~shift_reg[0] & shift_reg[10] & (^shift_reg[9:1]);
    assign is_prefix  = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
    assign push       = (state_reg == ST_CHECK) && frame_good && !is_prefix;
    assign push_data  = {rx_byte, ext_pend_reg, brk_pend_reg};

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg     <= ST_IDLE;
            bitcnt_reg    <= '0;
            shift_reg     <= '0;
            tcnt_reg      <= '0;
            ext_pend_reg  <= 1'b0;
            brk_pend_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (strobe_reg) begin
                        shift_reg  <= {10'b0, line_filt[1]};
                        bitcnt_reg <= 4'd1;
                        tcnt_reg   <= '0;
                        state_reg  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A strobe wins over a coincident timeout.
                    if (strobe_reg) begin
                        shift_reg[bitcnt_reg] <= line_filt[1];
                        bitcnt_reg            <= bitcnt_reg + 4'd1;
                        tcnt_reg              <= '0;
                        if (bitcnt_reg == 4'd10) begin
                            state_reg <= ST_CHECK;
                        end
                    end else if (tcnt_reg == TW'(TIMEOUT_CYCLES)) begin
                        state_reg     <= ST_IDLE;
                        bitcnt_reg    <= '0;
                        tcnt_reg      <= '0;
                        frame_err_reg <= 1'b1;
                        ext_pend_reg  <= 1'b0;
                        brk_pend_reg  <= 1'b0;
                    end else begin
                        tcnt_reg <= tcnt_reg + TW'(1);
                    end
                end
                ST_CHECK: begin
                    state_reg  <= ST_IDLE;
                    bitcnt_reg <= '0;
                    tcnt_reg   <= '0;
                    if (frame_good) begin
                        if (rx_byte == 8'hE0) begin
                            ext_pend_reg <= 1'b1;
                        end else if (rx_byte == 8'hF0) begin
                            brk_pend_reg <= 1'b1;
                        end else begin
                            ext_pend_reg <= 1'b0;
                            brk_pend_reg <= 1'b0;
                        end
                    end else begin
                        frame_err_reg <= 1'b1;
                        ext_pend_reg  <= 1'b0;
                        brk_pend_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    logic          fifo_valid;
    logic          fifo_full;
    logic          pop;
    logic          wr_en;
    logic [9:0]    head;

    assign fifo_valid = (count_reg != '0);
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign pop        = fifo_valid & evt.evt_ready;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign wr_en      = push & (~fifo_full | pop);
    assign head       = mem[rd_ptr_reg];

    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= push & fifo_full & ~pop;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload is forced to 0 while empty so every output reads 0 in reset.
    assign evt.evt_valid = fifo_valid;
    assign evt.evt_code  = fifo_valid ? head[9:2] : 8'h00;
    assign evt.evt_ext   = fifo_valid & head[1];
    assign evt.evt_break = fifo_valid & head[0];
    assign oFRAME_ERR    = frame_err_reg;
    assign oOVERFLOW     = overflow_reg;

endmodule

// File: tb/tb_ps2_key_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_rx
// Directed frames drive the PS/2 pins; expected events are pushed into a
// scoreboard queue at stimulus time and a monitor pops/compares on every
// accepted event. Error and overflow pulses are counted by the monitor and
// compared against expected totals at checkpoints.
// -----------------------------------------------------------------------------
module tb_ps2_key_rx;

    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int FD   = 4;
    localparam int HALF = 20;      // PS/2 half period in system clocks
    localparam int LAT  = FL + 5;  // stop-bit clock fall to oEVT_VALID

    logic clk;
    logic rst_n;
    logic ps2_clk;
    logic ps2_dat;
    logic frame_err;
    logic overflow;

    ps2_key_rx_if evt_if ();

    ps2_key_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (FD)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iPS2_CLK  (ps2_clk),
        .iPS2_DAT  (ps2_dat),
        .evt       (evt_if),
        .oFRAME_ERR(frame_err),
        .oOVERFLOW (overflow)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] sb[$];
    int         err_seen = 0;
    int         ovf_seen = 0;
    int         exp_err  = 0;
    int         exp_ovf  = 0;
    int         stop_fall_cyc = 0;
    int         last_rise_cyc = 0;
    logic       valid_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen <= err_seen + 1;
            if (overflow)  ovf_seen <= ovf_seen + 1;
            if (evt_if.evt_valid && !valid_prev) last_rise_cyc <= cyc;
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got code=%h ext=%b brk=%b expected none",
                             evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break);
                end else begin
                    logic [9:0] e;
                    e = sb.pop_front();
                    $display("evt  cyc=%0d code=%h ext=%b brk=%b (exp %h %b %b)", cyc,
                             evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break, e[9:2], e[1], e[0]);
                    check("evt_code",  {24'h0, evt_if.evt_code}, {24'h0, e[9:2]});
                    check("evt_ext",   {31'h0, evt_if.evt_ext},   {31'h0, e[1]});
                    check("evt_break", {31'h0, evt_if.evt_break}, {31'h0, e[0]});
                end
            end
        end
        valid_prev <= evt_if.evt_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Sends the low nbits of a frame. With glitch set, bit 3 gets a 3-cycle
    // low pulse during its clock-high phase and bit 5 a 3-cycle high pulse
    // during its clock-low phase.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            if (glitch && i == 3) begin
                wait_cyc(HALF / 2);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF - HALF / 2 - 3);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            stop_fall_cyc = cyc;
            if (glitch && i == 5) begin
                wait_cyc(HALF / 2);
                ps2_clk = 1'b1;
                wait_cyc(3);
                ps2_clk = 1'b0;
                wait_cyc(HALF - HALF / 2 - 3);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        wait_cyc(HALF);
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        $display("send byte=%h bad_parity=%0d glitch=%0d", b, bad_par, glitch);
        send_bits(frame(b, bad_par), 11, glitch);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    initial begin
        rst_n             = 1'b0;
        ps2_clk           = 1'b1;
        ps2_dat           = 1'b1;
        evt_if.evt_ready  = 1'b0;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(3);

        // Reset state
        check("rst_valid",     {31'h0, evt_if.evt_valid}, 0);
        check("rst_code",      {24'h0, evt_if.evt_code},  0);
        check("rst_frame_err", {31'h0, frame_err},        0);
        check("rst_overflow",  {31'h0, overflow},         0);

        // 1C: latency and hold while not ready
        sb.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C, 0, 0);
        check("latency", last_rise_cyc - stop_fall_cyc, LAT);
        wait_cyc(10);
        check("hold_valid", {31'h0, evt_if.evt_valid}, 1);
        check("hold_code",  {24'h0, evt_if.evt_code},  32'h1C);
        evt_if.evt_ready = 1'b1;
        wait_cyc(3);
        check("pop_empty", {31'h0, evt_if.evt_valid}, 0);
        drain("drain_1c");

        // E0 F0 75 -> single extended break event
        sb.push_back({8'h75, 1'b1, 1'b1});
        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h75, 0, 0);
        drain("drain_e0f075");
        check("err_after_prefix", err_seen, exp_err);

        // Bad-parity F0 clears pend flags
        exp_err++;
        sb.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'hF0, 1, 0);
        send_byte(8'h1C, 0, 0);
        drain("drain_badpar");
        check("err_badpar", err_seen, exp_err);

        // Overflow: 01..06 with consumer stalled
        evt_if.evt_ready = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            if (b <= FD) sb.push_back({8'(b), 1'b0, 1'b0});
            send_byte(8'(b), 0, 0);
        end
        exp_ovf += 2;
        check("ovf_count", ovf_seen, exp_ovf);
        check("full_valid", {31'h0, evt_if.evt_valid}, 1);
        @(posedge clk);
        #1;
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        check("drain_c0_valid", {31'h0, evt_if.evt_valid}, 1);
        repeat (3) @(negedge clk);
        check("drain_c3_valid", {31'h0, evt_if.evt_valid}, 1);
        @(negedge clk);
        check("drain_c4_empty", {31'h0, evt_if.evt_valid}, 0);
        check("drain_ovf_sb", sb.size(), 0);

        // Timeout after 5 clock pulses, then good 29
        send_bits(frame(8'h29, 0), 5, 0);
        wait_cyc(TO + 50);
        exp_err++;
        check("err_timeout", err_seen, exp_err);
        sb.push_back({8'h29, 1'b0, 1'b0});
        send_byte(8'h29, 0, 0);
        drain("drain_29");

        // Glitches on the PS/2 clock mid-frame
        sb.push_back({8'h4B, 1'b0, 1'b0});
        send_byte(8'h4B, 0, 1);
        drain("drain_glitch");
        check("err_glitch", err_seen, exp_err);

        // Reset mid-frame with an event queued
        evt_if.evt_ready = 1'b0;
        sb.push_back({8'h12, 1'b0, 1'b0});
        send_byte(8'h12, 0, 0);
        check("pre_rst_valid", {31'h0, evt_if.evt_valid}, 1);
        send_bits(frame(8'h33, 0), 4, 0);
        ps2_clk = 1'b0;          // hold the bus mid-bit when reset hits
        wait_cyc(2);
        #5;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'h0, evt_if.evt_valid},  0);
        check("midrst_code",  {24'h0, evt_if.evt_code},   0);
        check("midrst_ext",   {31'h0, evt_if.evt_ext},    0);
        check("midrst_brk",   {31'h0, evt_if.evt_break},  0);
        check("midrst_err",   {31'h0, frame_err},         0);
        sb.delete();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        wait_cyc(10);
        sb.push_back({8'h5A, 1'b0, 1'b0});
        send_byte(8'h5A, 0, 0);
        drain("drain_after_rst");

        wait_cyc(20);
        check("final_err", err_seen, exp_err);
        check("final_ovf", ovf_seen, exp_ovf);
        check("final_valid", {31'h0, evt_if.evt_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

endmodule
